// File: rtl/mips_pkg.sv
// mips_pkg -- constants and types shared by the MIPS core stages
// (register file, ALU, decode, write-back).
//   DATA_W / ADDR_W : machine word width and register index width
//   REG_ZERO        : index of the hardwired-zero register $0
//   reg_addr_t      : register index type
//   word_t          : machine word type
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : mips_pkg

// File: rtl/mips_reg_file_if.sv
// mips_reg_file_if -- read/write bus of the general-purpose register file.
//   rs_addr / rt_addr : read port A / B indices
//   wr_en / wr_addr / wr_data : write-back strobe, index and value
//   reg1 / reg2       : read port A / B data (to the ALU operands)
// Modports: master = decode/write-back side, slave = register file.
interface mips_reg_file_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    input  reg1, reg2
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    output reg1, reg2
  );

endinterface : mips_reg_file_if

// File: rtl/mips_reg_file_rdport.sv
// mips_reg_file_rdport -- one combinational register-file read port.
// Applies the reset mask and the $0 mask to the selected storage word and,
// when MIPS_REG_FILE_BYPASS_EN is defined, forwards the in-flight write-back
// value when it targets the addressed register.
//   rst_n    : active-low reset; output is forced to zero while low
//   rd_addr  : register index being read
//   rd_mem   : stored contents of mem[rd_addr]
//   wr_en / wr_addr / wr_data : in-flight write (bypass build only)
//   rd_data  : read data
module mips_reg_file_rdport #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_mem,
`ifdef MIPS_REG_FILE_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(mips_pkg::REG_ZERO);

  // NOTE: every output of an always_comb block is given a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rd_data = rd_mem;
`ifdef MIPS_REG_FILE_BYPASS_EN
    // wr_addr != 0 is implied: the $0 check below overrides any forward.
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
    // Reset and $0 win over both stored data and forwarded data.
    if (!rst_n || (rd_addr == ZERO_IDX)) begin
      rd_data = '0;
    end
  end

endmodule : mips_reg_file_rdport

// File: rtl/mips_reg_file.sv
// mips_reg_file -- 32 x 32 general-purpose register file of the MIPS core.
// Two combinational read ports (rs -> reg1, rt -> reg2) feed the ALU; one
// write port driven by the write-back stage updates storage on rising clk.
// Register $0 always reads zero and writes to it are dropped.
// Optional macro MIPS_REG_FILE_BYPASS_EN: same-cycle write-to-read forwarding.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; loads RESET_VAL into every entry
//   bus   : mips_reg_file_if.slave (addresses, write strobe/data, reg1/reg2)
module mips_reg_file #(
  parameter int                DATA_W    = mips_pkg::DATA_W,
  parameter int                ADDR_W    = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_reg_file_if.slave   bus
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(mips_pkg::REG_ZERO);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // NOTE: the storage array is reset on purpose: every entry must read a
  // defined value after reset. This rules out a RAM macro, which is
  // acceptable for a 32-entry flop array.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (bus.wr_en && (bus.wr_addr != ZERO_IDX)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  mips_reg_file_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_rs (
    .rst_n   (rst_n),
    .rd_addr (bus.rs_addr),
    .rd_mem  (mem[bus.rs_addr]),
`ifdef MIPS_REG_FILE_BYPASS_EN
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
`endif
    .rd_data (bus.reg1)
  );

  mips_reg_file_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_rt (
    .rst_n   (rst_n),
    .rd_addr (bus.rt_addr),
    .rd_mem  (mem[bus.rt_addr]),
`ifdef MIPS_REG_FILE_BYPASS_EN
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
`endif
    .rd_data (bus.reg2)
  );

endmodule : mips_reg_file
